atm_pin_entry: RTL and testbench
================================

# atm_pin_entry

PIN entry and verification stage sitting directly upstream of the ATM control FSM (`atm_fsm`). It collects BCD keypad digits after card insertion and compares them against the card's stored PIN. It produces the one-cycle `pin_correct` pulse that the control FSM waits on in its PIN state, and enforces the retry limit, lockout and inactivity timeout.

## Interface
Parameters:
- `PIN_DIGITS`, default 4: number of BCD digits per PIN.
- `MAX_TRIES`, default 3: failed attempts allowed before lockout.
- `TIMEOUT_CYC`, default 1000: idle cycles in entry before abort (≥2).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: sole clock, rising edge.
  - `rst_n` in 1: asynchronous, active-low reset.
- Card and PIN inputs:
  - `card_inserted` in 1: level, card present; same signal fed to `atm_fsm`.
  - `stored_pin` in 4*PIN_DIGITS: card PIN, BCD, digit 0 in MSBs; stable while card present.
- Keypad inputs:
  - `key_valid` in 1: one-cycle strobe, `key_digit` valid.
  - `key_digit` in 4: BCD digit 0–9.
  - `key_enter` in 1: one-cycle strobe, submit entry.
  - `key_clear` in 1: one-cycle strobe, erase entry.
- Outputs:
  - `pin_correct` out 1: one-cycle pulse, PIN matched; drives `atm_fsm.pin_correct`.
  - `pin_fail` out 1: one-cycle pulse, attempt rejected.
  - `pin_timeout` out 1: one-cycle pulse, inactivity abort.
  - `card_retain` out 1: level, lockout active; card must be kept.
  - `digit_count` out $clog2(PIN_DIGITS+1): digits currently held, for display masking.

## Operation
- States:
  - IDLE: waits for a card. `card_inserted`=1 moves to COLLECT; the buffer, `digit_count`, try counter and timer are all cleared.
  - COLLECT: accepts key strobes.
    - `key_valid` with `key_digit`≤9 and `digit_count`<PIN_DIGITS: digit is shifted into the buffer, `digit_count`+1, timer reset.
    - Digit >9, or buffer already full: ignored; the timer is still reset.
    - `key_clear`: buffer and `digit_count` go to 0, timer reset.
    - `key_enter` with `digit_count`==PIN_DIGITS: move to CHECK.
    - `key_enter` with fewer digits: treated as a mismatch, move to CHECK with the forced-fail flag set.
  - CHECK: single cycle. The comparison is evaluated here.
    - Match: `pin_correct` pulse, move to WAIT_REMOVE.
    - Mismatch: `pin_fail` pulse and tries+1. If tries reaches MAX_TRIES, move to LOCKED. Otherwise return to COLLECT with the buffer, `digit_count` and timer cleared.
  - WAIT_REMOVE: all keys are ignored. `card_inserted`=0 moves to IDLE.
  - LOCKED: `card_retain`=1 and keys are ignored. `card_inserted`=0 moves to IDLE and drops `card_retain`.
- Simultaneous strobes in one cycle: priority is `key_clear` > `key_enter` > `key_valid`. Only the highest-priority strobe acts.
- Card removal: `card_inserted`=0 in COLLECT or CHECK forces IDLE with no pulse. Removal takes priority over any key or compare result in that cycle.
- Timeout: the timer counts in COLLECT only. When it reaches TIMEOUT_CYC-1 with no key, `pin_timeout` pulses and the state moves to WAIT_REMOVE. The try count is unchanged and there is no lockout.
- Widths:
  - Try counter: $clog2(MAX_TRIES+1) bits.
  - Timer: $clog2(TIMEOUT_CYC) bits, saturating.
  - Counters never wrap.
- Reset (`rst_n`=0, any state, including mid-entry or mid-lockout): IDLE. All counters and the buffer go to 0. All outputs go to 0, including `card_retain`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `key_enter` sampled at edge N: CHECK from N. `pin_correct`/`pin_fail` are high for exactly the cycle after edge N+1, so latency is 2 cycles.
- `digit_count` updates one cycle after the accepted strobe.
- `pin_timeout` is high for one cycle, starting the edge after the timer reaches TIMEOUT_CYC-1.
- `card_retain` asserts with the final `pin_fail` pulse. It stays high until the edge after `card_inserted` falls.
- `atm_fsm` enters its PIN state 2 cycles after card insertion. `pin_correct` cannot arrive earlier than that, because it needs at least PIN_DIGITS+1 key strobes.

## Structure
- Package `atm_pkg`:
  - `pin_state_t` enum (IDLE, COLLECT, CHECK, WAIT_REMOVE, LOCKED).
  - `bcd_t` (logic [3:0]).
  - Constant `BCD_MAX`=9.
- Sub-module `atm_pin_timer`: clear/enable inputs and a one-cycle `expire` output at TIMEOUT_CYC-1. It is instantiated once.
- The FSM, digit buffer, comparator and try counter stay in `atm_pin_entry`.

## Test plan
- Correct PIN:
  - Stimulus: insert card, `stored_pin`=16'h1234; keys 1,2,3,4, enter.
  - Response: `pin_correct` pulse 2 cycles after enter, `pin_fail`=0.
  - Response: `digit_count` steps 1–4, then the state holds in WAIT_REMOVE until removal.
- Three wrong attempts:
  - Stimulus: 1,2,3,5 + enter, three times.
  - Response: three `pin_fail` pulses; `card_retain`=1 with the third.
  - Response: further keys are ignored; card removal clears `card_retain`.
- Short entry and clear:
  - Stimulus: keys 1,2, enter.
  - Response: `pin_fail`.
  - Stimulus: keys 9,9, clear, then 1,2,3,4, enter.
  - Response: `pin_correct`; tries was 1 and no lockout occurs.
- Boundaries:
  - Stimulus: `key_digit`=4'hA.
  - Response: ignored.
  - Stimulus: a fifth digit.
  - Response: ignored.
  - Stimulus: clear and enter in the same cycle.
  - Response: clear wins, `digit_count`=0, no pulse.
- Timeout, then reset mid-lockout:
  - Stimulus: TIMEOUT_CYC=16, no keys.
  - Response: `pin_timeout` pulse after 16 cycles.
  - Stimulus: assert `rst_n`=0 during LOCKED.
  - Response: all outputs 0 immediately (asynchronously).
- Card pulled mid-entry:
  - Stimulus: 3 digits entered, then `card_inserted`=0.
  - Response: IDLE, no pulses.
  - Stimulus: reinsert the card.
  - Response: `digit_count`=0 and tries=0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN entry stage.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        WAIT_REMOVE,
        LOCKED
    } pin_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/atm_pin_timer.sv
// Saturating inactivity timer; expire flags the final idle cycle of entry.
module atm_pin_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en && (cnt_q != T_LAST))
            cnt_q <= cnt_q + 1'b1;
    end

    // A clear in the same cycle means activity, so it cancels expiry.
    assign expire = en && !clr && (cnt_q == T_LAST);

endmodule

// File: rtl/atm_pin_entry.sv
// PIN collection and verification ahead of the ATM control FSM: retry limit,
// lockout and inactivity timeout, with all outputs registered.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              card_inserted,
    input  logic [4*PIN_DIGITS-1:0]           stored_pin,
    input  logic                              key_valid,
    input  bcd_t                              key_digit,
    input  logic                              key_enter,
    input  logic                              key_clear,
    output logic                              pin_correct,
    output logic                              pin_fail,
    output logic                              pin_timeout,
    output logic                              card_retain,
    output logic [$clog2(PIN_DIGITS+1)-1:0]   digit_count
);

    localparam int CW  = $clog2(PIN_DIGITS + 1);
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int PW  = 4 * PIN_DIGITS;
    localparam logic [CW-1:0]  CNT_FULL = CW'(PIN_DIGITS);
    localparam logic [TRW-1:0] TRY_MAX  = TRW'(MAX_TRIES);
    localparam logic [TRW-1:0] TRY_LAST = TRW'(MAX_TRIES - 1);

    pin_state_t      state_q, state_d;
    logic [PW-1:0]   pin_buf_q;
    logic [TRW-1:0]  tries_q;
    logic            force_fail_q;
    logic            any_key, tmr_clr, tmr_en, tmr_expire;
    logic            pin_match, last_try, clear_all;
    logic            pin_correct_d, pin_fail_d, pin_timeout_d, card_retain_d;

    assign any_key   = key_valid | key_enter | key_clear;
    assign pin_match = !force_fail_q && (pin_buf_q == stored_pin);
    assign last_try  = (tries_q == TRY_LAST);
    assign tmr_en    = (state_q == COLLECT);
    assign tmr_clr   = (state_q != COLLECT) || any_key;

    atm_pin_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Card removal outranks keys and the compare result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (card_inserted) state_d = COLLECT;
            COLLECT: begin
                if (!card_inserted)  state_d = IDLE;
                else if (key_clear)  state_d = COLLECT;
                else if (key_enter)  state_d = CHECK;
                else if (tmr_expire) state_d = WAIT_REMOVE;
            end
            CHECK: begin
                if (!card_inserted) state_d = IDLE;
                else if (pin_match) state_d = WAIT_REMOVE;
                else if (last_try)  state_d = LOCKED;
                else                state_d = COLLECT;
            end
            WAIT_REMOVE: if (!card_inserted) state_d = IDLE;
            LOCKED:      if (!card_inserted) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        pin_correct_d = (state_q == CHECK) && card_inserted && pin_match;
        pin_fail_d    = (state_q == CHECK) && card_inserted && !pin_match;
        pin_timeout_d = (state_q == COLLECT) && card_inserted && tmr_expire;
        card_retain_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_correct <= 1'b0;
            pin_fail    <= 1'b0;
            pin_timeout <= 1'b0;
            card_retain <= 1'b0;
        end else begin
            pin_correct <= pin_correct_d;
            pin_fail    <= pin_fail_d;
            pin_timeout <= pin_timeout_d;
            card_retain <= card_retain_d;
        end
    end

    // Clearing on the way into IDLE blanks the display as soon as the card leaves.
    assign clear_all = (state_q == IDLE) || (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_buf_q    <= '0;
            digit_count  <= '0;
            tries_q      <= '0;
            force_fail_q <= 1'b0;
        end else if (clear_all) begin
            pin_buf_q    <= '0;
            digit_count  <= '0;
            tries_q      <= '0;
            force_fail_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (key_clear) begin
                        pin_buf_q   <= '0;
                        digit_count <= '0;
                    end else if (key_enter) begin
                        force_fail_q <= (digit_count != CNT_FULL);
                    end else if (key_valid && (key_digit <= BCD_MAX) && (digit_count < CNT_FULL)) begin
                        pin_buf_q   <= (pin_buf_q << 4) | PW'(key_digit);
                        digit_count <= digit_count + 1'b1;
                    end
                end
                CHECK: begin
                    if (!pin_match) begin
                        if (tries_q != TRY_MAX) tries_q <= tries_q + 1'b1;
                        if (!last_try) begin
                            pin_buf_q    <= '0;
                            digit_count  <= '0;
                            force_fail_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Randomized and directed checks of atm_pin_entry against a session-level
// reference model (digit queue, try count, idle count).
module tb_atm_pin_entry;

    localparam int P  = 4;
    localparam int MT = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n, card_inserted, key_valid, key_enter, key_clear;
    logic [3:0]  key_digit;
    logic [15:0] stored_pin;
    logic        pin_correct, pin_fail, pin_timeout, card_retain;
    logic [2:0]  digit_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit         m_active, m_pending, m_short, m_done, m_locked;
    int         m_q[$];
    int         m_tries, m_idle;
    logic       m_pc, m_pf, m_to, m_ret;
    logic [2:0] m_cnt;

    atm_pin_entry #(.PIN_DIGITS(P), .MAX_TRIES(MT), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .card_inserted (card_inserted),
        .stored_pin    (stored_pin),
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .key_enter     (key_enter),
        .key_clear     (key_clear),
        .pin_correct   (pin_correct),
        .pin_fail      (pin_fail),
        .pin_timeout   (pin_timeout),
        .card_retain   (card_retain),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_short = 0; m_done = 0; m_locked = 0;
        m_q.delete();
        m_tries = 0; m_idle = 0;
        m_pc = 0; m_pf = 0; m_to = 0; m_ret = 0; m_cnt = '0;
    endtask

    function automatic bit entry_matches();
        if (m_short || m_q.size() != P) return 0;
        for (int i = 0; i < P; i++)
            if (m_q[i] != int'(stored_pin[4*(P-1-i) +: 4])) return 0;
        return 1;
    endfunction

    // One clock of the session rules, using the inputs sampled at the edge.
    task automatic model_step();
        m_pc = 0; m_pf = 0; m_to = 0;
        if (!card_inserted) begin
            m_active = 0; m_pending = 0; m_short = 0; m_done = 0; m_locked = 0;
            m_q.delete(); m_tries = 0; m_idle = 0;
        end else if (!m_active && !m_pending && !m_done && !m_locked) begin
            m_active = 1; m_q.delete(); m_tries = 0; m_idle = 0;
        end else if (m_pending) begin
            m_pending = 0;
            if (entry_matches()) begin
                m_pc = 1; m_done = 1;
            end else begin
                m_pf = 1; m_tries++;
                if (m_tries >= MT) m_locked = 1;
                else begin
                    m_active = 1; m_q.delete(); m_idle = 0; m_short = 0;
                end
            end
        end else if (m_active) begin
            if (key_clear) begin
                m_q.delete(); m_idle = 0;
            end else if (key_enter) begin
                m_pending = 1; m_active = 0; m_short = (m_q.size() < P);
            end else if (key_valid) begin
                m_idle = 0;
                if (key_digit <= 4'd9 && m_q.size() < P) m_q.push_back(int'(key_digit));
            end else if (m_idle == TO - 1) begin
                m_to = 1; m_active = 0; m_done = 1;
            end else begin
                m_idle++;
            end
        end
        m_ret = m_locked;
        m_cnt = 3'(m_q.size());
    endtask

    // Codes: 0-15 digit, 16 enter, 17 clear, 18 idle, 19 clear+enter, 20 card out, 21 card in
    task automatic apply(input int c);
        key_valid = 0; key_enter = 0; key_clear = 0; key_digit = '0;
        if (c < 16) begin key_valid = 1; key_digit = 4'(c); end
        else if (c == 16) key_enter = 1;
        else if (c == 17) key_clear = 1;
        else if (c == 19) begin key_clear = 1; key_enter = 1; end
        else if (c == 20) card_inserted = 0;
        else if (c == 21) card_inserted = 1;
        @(posedge clk);
        model_step();
        #1;
        key_valid = 0; key_enter = 0; key_clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; card_inserted = 0; key_valid = 0; key_enter = 0; key_clear = 0;
        key_digit = '0; stored_pin = 16'h1234;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== {m_pc, m_pf, m_to, m_ret, m_cnt}) begin
            n_bad++;
            $display("FAIL reset: got %b want %b", {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, {m_pc, m_pf, m_to, m_ret, m_cnt});
        end
        rst_n = 1;
        apply(18);
        n_cmp++;
        if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== {m_pc, m_pf, m_to, m_ret, m_cnt}) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, {m_pc, m_pf, m_to, m_ret, m_cnt});
        end
    endtask

    task automatic run_seq(input string name, input int seq[$]);
        foreach (seq[i]) begin
            apply(seq[i]);
            n_cmp++;
            if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== {m_pc, m_pf, m_to, m_ret, m_cnt}) begin
                n_bad++;
                $display("FAIL %s step %0d: got %b want %b", name, i, {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, {m_pc, m_pf, m_to, m_ret, m_cnt});
            end
        end
    endtask

    task automatic test_correct_pin();
        int lat;
        stored_pin = 16'h1234;
        run_seq("correct_pin", {21, 1, 2, 3, 4});
        apply(16);
        lat = 0;
        for (int k = 1; k <= 4 && lat == 0; k++) begin
            apply(18);
            if (pin_correct === 1'b1) lat = k + 1;
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL correct_latency: got %0d want 2", lat);
        end
        run_seq("correct_hold", {5, 16, 17, 1, 18, 20, 18});
    endtask

    task automatic test_lockout();
        stored_pin = 16'h1234;
        run_seq("lockout", {21, 1, 2, 3, 5, 16, 18, 1, 2, 3, 5, 16, 18,
                            1, 2, 3, 5, 16, 18, 1, 2, 3, 4, 16, 18, 18});
        n_cmp++;
        if (card_retain !== 1'b1) begin
            n_bad++;
            $display("FAIL lockout_retain: got %b want 1", card_retain);
        end
        run_seq("lockout_remove", {20, 18});
    endtask

    task automatic test_short_clear();
        stored_pin = 16'h1234;
        run_seq("short_clear", {21, 1, 2, 16, 18, 9, 9, 17, 1, 2, 3, 4, 16, 18, 18, 20, 18});
    endtask

    task automatic test_boundaries();
        stored_pin = 16'h1234;
        run_seq("boundaries", {21, 10, 1, 2, 3, 4, 5, 19, 18, 18, 1, 2, 3, 4, 7, 15, 16, 18, 18, 20, 18});
    endtask

    task automatic test_timeout();
        int hit;
        stored_pin = 16'h5678;
        hit = 0;
        apply(21);
        for (int k = 1; k <= 20; k++) begin
            apply(18);
            n_cmp++;
            if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== {m_pc, m_pf, m_to, m_ret, m_cnt}) begin
                n_bad++;
                $display("FAIL timeout step %0d: got %b want %b", k, {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, {m_pc, m_pf, m_to, m_ret, m_cnt});
            end
            if (pin_timeout === 1'b1 && hit == 0) hit = k;
        end
        n_cmp++;
        if (hit != TO) begin
            n_bad++;
            $display("FAIL timeout_cycle: got %0d want %0d", hit, TO);
        end
        run_seq("timeout_remove", {5, 16, 18, 20, 18});
    endtask

    task automatic test_card_pull();
        stored_pin = 16'h2468;
        run_seq("card_pull", {21, 1, 1, 1, 1, 16, 18, 1, 1, 1, 1, 16, 18, 1, 2, 3, 20, 18,
                              21, 18, 1, 1, 1, 1, 16, 18, 1, 1, 1, 1, 16, 18, 18, 20, 18});
    endtask

    task automatic test_random();
        int c, r, burst;
        burst = 0;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if (burst > 0) begin
                c = 18; burst--;
            end else if (!card_inserted) begin
                c = (r < 30) ? 21 : 18;
                if (c == 21)
                    for (int d = 0; d < P; d++) stored_pin[4*d +: 4] = 4'($urandom_range(0, 9));
            end else if (r < 2)  c = 20;
            else if (r < 10) c = 16;
            else if (r < 14) c = 17;
            else if (r < 15) c = 19;
            else if (r < 60) begin
                if ($urandom_range(0, 1) == 1 && m_q.size() < P)
                    c = int'(stored_pin[4*(P-1-m_q.size()) +: 4]);
                else
                    c = $urandom_range(0, 11);
            end else begin
                c = 18;
                if (r == 99) burst = 20;
            end
            apply(c);
            n_cmp++;
            if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== {m_pc, m_pf, m_to, m_ret, m_cnt}) begin
                n_bad++;
                $display("FAIL random cycle %0d code %0d: got %b want %b", k, c, {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, {m_pc, m_pf, m_to, m_ret, m_cnt});
            end
        end
        run_seq("random_end", {20, 18});
    endtask

    task automatic test_reset_locked();
        stored_pin = 16'h1357;
        run_seq("reset_locked", {21, 1, 1, 1, 1, 16, 18, 2, 2, 2, 2, 16, 18, 3, 3, 3, 3, 16, 18});
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({pin_correct, pin_fail, pin_timeout, card_retain, digit_count} !== 7'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want %b", {pin_correct, pin_fail, pin_timeout, card_retain, digit_count}, 7'b0);
        end
        model_reset();
        card_inserted = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        run_seq("after_reset", {21, 4, 18});
    endtask

    initial begin
        test_reset();
        test_correct_pin();
        test_lockout();
        test_short_clear();
        test_boundaries();
        test_timeout();
        test_card_pull();
        test_random();
        test_reset_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
